// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op codes, write-back
// source codes and the HI/LO sequencer state encoding.
package mdu_defs;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  // Write-back source select shared with the forwarding and control logic.
  typedef enum logic [1:0] {
    RFWD_ALU  = 2'b00,
    RFWD_DM   = 2'b01,
    RFWD_PC4  = 2'b10,
    RFWD_HILO = 2'b11
  } rfwd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_arith(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// E-stage request / HI-LO response bundle between the pipeline and mdu_hilo.
interface mdu_hilo_if;
  import mdu_defs::*;

  logic        start;
  mdu_op_e     mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_out;

  modport master (
    output start, mdu_op, A, B,
    input  busy, hi, lo, hilo_out
  );

  modport slave (
    input  start, mdu_op, A, B,
    output busy, hi, lo, hilo_out
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply / divide core producing a packed {hi,lo} result.
module mdu_arith
  import mdu_defs::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Signed division runs on magnitudes; signs are restored afterwards so the
  // quotient truncates toward zero and the remainder follows the dividend.
  always_comb begin
    a_neg   = (op == MDU_DIV) && a[31];
    b_neg   = (op == MDU_DIV) && b[31];
    a_mag   = a_neg ? (~a + 32'd1) : a;
    b_mag   = b_neg ? (~b + 32'd1) : b;
    divisor = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
  end

  // NOTE: every output is given a default first so no path leaves a latch.
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    unique case (op)
      MDU_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MDU_MULTU: result = {32'd0, a} * {32'd0, b};
      MDU_DIV, MDU_DIVU: begin
        div_by_zero = (b == 32'd0);
        result[31:0]  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        result[63:32] = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning HI/LO: fixed-latency busy window,
// atomic HI/LO commit at the end, MTHI/MTLO writes and MFHI/MFLO read mux.
module mdu_hilo
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic         clk,
  input logic         reset,
  mdu_hilo_if.slave   bus
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      pend_result;
  logic             pend_write;

  logic [63:0]      arith_result;
  logic             arith_dbz;

  mdu_arith u_arith (
    .op          (bus.mdu_op),
    .a           (bus.A),
    .b           (bus.B),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  // The result is captured at start so later operand changes cannot disturb
  // it; HI/LO only change together at the final busy edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the pending result is reset too, so an aborted operation can
      // never leak a stale value into HI/LO.
      state       <= ST_IDLE;
      cnt         <= '0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_result <= 64'd0;
      pend_write  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start && is_arith(bus.mdu_op)) begin
            pend_result <= arith_result;
            pend_write  <= !arith_dbz;
            cnt         <= is_div(bus.mdu_op) ? CNT_W'(DIV_CYCLES)
                                              : CNT_W'(MULT_CYCLES);
            busy_q      <= 1'b1;
            state       <= ST_BUSY;
          end else if (bus.mdu_op == MDU_MTHI) begin
            hi_q <= bus.A;
          end else if (bus.mdu_op == MDU_MTLO) begin
            lo_q <= bus.A;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (pend_write) begin
              hi_q <= pend_result[63:32];
              lo_q <= pend_result[31:0];
            end
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.hilo_out = 32'd0;
    if (bus.mdu_op == MDU_MFHI)      bus.hilo_out = hi_q;
    else if (bus.mdu_op == MDU_MFLO) bus.hilo_out = lo_q;
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_mdu_hilo;
  import mdu_defs::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_hilo_if bus ();

  mdu_hilo #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO after an arithmetic op, from plain 64-bit arithmetic.
  task automatic model_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MULT: begin
        sp = sa * sb;
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      MDU_MULTU: begin
        up = ua * ub;
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      MDU_DIV: if (b != 32'd0) begin
        sq = sa / sb; sr = sa % sb;
        m_lo = sq[31:0]; m_hi = sr[31:0];
      end
      MDU_DIVU: if (b != 32'd0) begin
        m_lo = a / b; m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Issue one arithmetic op, measure the busy window, then check HI/LO.
  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject_mtlo);
    int n;
    int exp_n;
    exp_n = (op == MDU_DIV || op == MDU_DIVU) ? DIV_N : MULT_N;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = inject_mtlo ? MDU_MTLO : MDU_NONE;
    bus.A      = 32'h5555_5555;
    bus.B      = 32'd0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      if (n == 3) bus.mdu_op = MDU_NONE;
    end
    bus.mdu_op = MDU_NONE;
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    model_op(op, a, b);
    check({tag, "_hi"}, bus.hi, m_hi);
    check({tag, "_lo"}, bus.lo, m_lo);
  endtask

  task automatic move_to(input mdu_op_e op, input logic [31:0] a);
    @(negedge clk);
    bus.mdu_op = op;
    bus.A      = a;
    @(negedge clk);
    bus.mdu_op = MDU_NONE;
    if (op == MDU_MTHI) m_hi = a;
    if (op == MDU_MTLO) m_lo = a;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    bus.A      = 32'd0;
    bus.B      = 32'd0;

    // Reset state
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed multiply/divide cases
    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.lo, 32'hFFFF_FFF1);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("multu_hi_const", bus.hi, 32'h0000_0004);
    check("multu_lo_const", bus.lo, 32'hFFFF_FFF1);
    run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    run_op("divu", MDU_DIVU, 32'd7, 32'd2, 1'b0);
    check("divu_lo_const", bus.lo, 32'd3);
    check("divu_hi_const", bus.hi, 32'd1);

    // Divide by zero keeps HI/LO; then the signed overflow corner
    move_to(MDU_MTHI, 32'h11);
    move_to(MDU_MTLO, 32'h22);
    run_op("div0", MDU_DIV, 32'd1234, 32'd0, 1'b0);
    check("div0_hi_const", bus.hi, 32'h11);
    check("div0_lo_const", bus.lo, 32'h22);
    run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divovf_lo_const", bus.lo, 32'h8000_0000);
    check("divovf_hi_const", bus.hi, 32'd0);

    // MTHI while idle, MFHI/MFLO read mux
    move_to(MDU_MTHI, 32'hABCD);
    check("mthi_hi", bus.hi, 32'hABCD);
    bus.mdu_op = MDU_MFHI;
    #1 check("mfhi_out", bus.hilo_out, 32'hABCD);
    bus.mdu_op = MDU_MFLO;
    #1 check("mflo_out", bus.hilo_out, m_lo);
    bus.mdu_op = MDU_NONE;
    #1 check("none_out", bus.hilo_out, 32'd0);

    // MTLO during a busy MULT is ignored
    run_op("mtlo_busy", MDU_MULT, 32'd6, 32'd7, 1'b1);
    check("mtlo_busy_lo_const", bus.lo, 32'd42);

    // Start with a non-arithmetic op is ignored
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MFHI;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    check("nonarith_busy", 32'(bus.busy), 32'd0);

    // Reset mid-operation discards the pending result
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MULT;
    bus.A      = 32'd3;
    bus.B      = 32'd4;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("postrst_hi", bus.hi, 32'd0);
    check("postrst_lo", bus.lo, 32'd0);
    check("postrst_busy", 32'(bus.busy), 32'd0);
    run_op("after_rst", MDU_MULT, 32'd3, 32'd4, 1'b0);
    check("after_rst_lo_const", bus.lo, 32'd12);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      int          sel;
      logic [31:0] ra, rb;
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if (sel < 7) begin
        run_op($sformatf("rnd%0d", i), mdu_op_e'(4'($urandom_range(1, 4))), ra, rb, 1'($urandom_range(0, 1)));
      end else if (sel == 7) begin
        move_to(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, ra);
        check($sformatf("rnd%0d_mt_hi", i), bus.hi, m_hi);
        check($sformatf("rnd%0d_mt_lo", i), bus.lo, m_lo);
      end else begin
        bus.mdu_op = (sel == 8) ? MDU_MFHI : MDU_MFLO;
        #1 check($sformatf("rnd%0d_mf", i), bus.hilo_out, (sel == 8) ? m_hi : m_lo);
        bus.mdu_op = MDU_NONE;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
